// File: rtl/link_align_sequencer.sv
// link_align_sequencer
// Bring-up sequencer for the per-link receive path. Once started it walks the
// enabled links in ascending order and runs reset, automatic delay alignment,
// an error-counter dwell and a final error/eye check on each one. Each link
// ends the run marked locked or failed. Only the link being sequenced is ever
// driven, so the per-link control pulses never overlap between links.

module link_align_sequencer #(
  parameter int NLINKS        = 12,
  parameter int COUNTER_WIDTH = 32,
  parameter int RST_CYCLES    = 4,
  parameter int SETTLE_CYCLES = 4096,
  parameter int DWELL_CYCLES  = 16384,
  parameter int MAX_RETRIES   = 3,
  parameter int ERR_THRESHOLD = 0,
  parameter int MIN_EYE       = 16
) (
  input  logic                              clk160,
  input  logic                              rstb,
  input  logic                              start,
  input  logic                              abort,
  input  logic [NLINKS-1:0]                 link_enable,
  input  logic [NLINKS-1:0]                 delay_ready,
  input  logic [NLINKS-1:0]                 waiting_trans,
  input  logic [NLINKS*COUNTER_WIDTH-1:0]   error_counter,
  input  logic [NLINKS*9-1:0]               eye_width,
  output logic [NLINKS-1:0]                 link_resetn,
  output logic [NLINKS-1:0]                 counter_reset,
  output logic [NLINKS-1:0]                 latch_counters,
  output logic [NLINKS-1:0]                 delay_mode,
  output logic                              busy,
  output logic                              done,
  output logic [$clog2(NLINKS)-1:0]         cur_link,
  output logic [NLINKS-1:0]                 link_locked,
  output logic [NLINKS-1:0]                 link_failed
);

  localparam int LW = $clog2(NLINKS);
  localparam int AW = $clog2(MAX_RETRIES + 1);
  localparam logic [LW-1:0] LAST_LINK = LW'(NLINKS - 1);

  typedef enum logic [3:0] {
    S_IDLE,
    S_SCAN,
    S_RESET,
    S_SETTLE,
    S_CLEAR,
    S_DWELL,
    S_LATCH,
    S_CHECK,
    S_RETRY,
    S_FINISH
  } state_t;

  state_t                   state;
  logic [NLINKS-1:0]        en_q;      // enable snapshot taken at start
  logic [NLINKS-1:0]        visited;   // links already finished this run
  logic [31:0]              cnt;       // phase timer (reset, settle, dwell, latch wait)
  logic [AW-1:0]            attempt;   // failed attempts on the current link

  logic [NLINKS-1:0]        pending;
  logic                     scan_found;
  logic [LW-1:0]            scan_idx;
  logic                     cur_ready;
  logic                     cur_wait;
  logic [COUNTER_WIDTH-1:0] cur_err;
  logic [8:0]               cur_eye;
  logic                     check_pass;
  logic                     cur_last;

  assign pending  = en_q & ~visited;
  assign cur_last = (cur_link == LAST_LINK);

  // Lowest enabled link not yet sequenced in this run.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    scan_found = 1'b0;
    scan_idx   = '0;
    for (int i = NLINKS - 1; i >= 0; i--) begin
      if (pending[i]) begin
        scan_found = 1'b1;
        scan_idx   = LW'(i);
      end
    end
  end

  // Status of the link currently being sequenced and the lock decision.
  always_comb begin
    cur_ready  = delay_ready[cur_link];
    cur_wait   = waiting_trans[cur_link];
    cur_err    = error_counter[int'(cur_link)*COUNTER_WIDTH +: COUNTER_WIDTH];
    cur_eye    = eye_width[int'(cur_link)*9 +: 9];
    check_pass = (cur_err <= COUNTER_WIDTH'(ERR_THRESHOLD)) && (cur_eye >= 9'(MIN_EYE));
  end

  // Sequencer FSM with registered per-link controls and status.
  always_ff @(posedge clk160 or negedge rstb) begin
    // NOTE: every register, including the enable snapshot and visited mask, is reset so a run never starts from stale state.
    if (!rstb) begin
      state          <= S_IDLE;
      en_q           <= '0;
      visited        <= '0;
      cnt            <= '0;
      attempt        <= '0;
      link_resetn    <= '1;
      counter_reset  <= '0;
      latch_counters <= '0;
      delay_mode     <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      cur_link       <= '0;
      link_locked    <= '0;
      link_failed    <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments; later assignments in this block override these pulse defaults.
      counter_reset  <= '0;
      latch_counters <= '0;
      done           <= 1'b0;

      if (abort && state != S_IDLE && state != S_FINISH) begin
        // Clean stop: release every reset, keep earned flags, drop delay mode on an unfinished link.
        link_resetn <= '1;
        if (!link_locked[cur_link]) delay_mode[cur_link] <= 1'b0;
        state <= S_FINISH;
      end else begin
        case (state)
          S_IDLE: begin
            if (start && !abort) begin
              en_q        <= link_enable;
              visited     <= '0;
              link_locked <= '0;
              link_failed <= '0;
              cur_link    <= '0;
              attempt     <= '0;
              busy        <= |link_enable;
              state       <= S_SCAN;
            end
          end

          S_SCAN: begin
            if (scan_found) begin
              cur_link              <= scan_idx;
              attempt               <= '0;
              link_resetn[scan_idx] <= 1'b0;
              delay_mode[scan_idx]  <= 1'b1;
              cnt                   <= '0;
              state                 <= S_RESET;
            end else begin
              state <= S_FINISH;
            end
          end

          S_RESET: begin
            if (cnt == 32'(RST_CYCLES - 1)) begin
              link_resetn[cur_link] <= 1'b1;
              cnt                   <= '0;
              state                 <= S_SETTLE;
            end else begin
              cnt <= cnt + 32'd1;
            end
          end

          S_SETTLE: begin
            if (cur_ready && !cur_wait) begin
              counter_reset[cur_link] <= 1'b1;
              cnt                     <= '0;
              state                   <= S_CLEAR;
            end else if (cnt == 32'(SETTLE_CYCLES - 1)) begin
              state <= S_RETRY;
            end else begin
              cnt <= cnt + 32'd1;
            end
          end

          S_CLEAR: state <= S_DWELL;

          S_DWELL: begin
            if (!cur_ready) begin
              state <= S_RETRY;
            end else if (cnt == 32'(DWELL_CYCLES - 1)) begin
              latch_counters[cur_link] <= 1'b1;
              cnt                      <= '0;
              state                    <= S_LATCH;
            end else begin
              cnt <= cnt + 32'd1;
            end
          end

          // Latch pulse cycle plus two cycles for the latched count to arrive.
          S_LATCH: begin
            if (cnt == 32'd2) state <= S_CHECK;
            else              cnt   <= cnt + 32'd1;
          end

          S_CHECK: begin
            if (check_pass) begin
              link_locked[cur_link] <= 1'b1;
              visited[cur_link]     <= 1'b1;
              state                 <= cur_last ? S_FINISH : S_SCAN;
            end else begin
              state <= S_RETRY;
            end
          end

          S_RETRY: begin
            if (int'(attempt) + 1 < MAX_RETRIES) begin
              attempt               <= attempt + 1'b1;
              link_resetn[cur_link] <= 1'b0;
              delay_mode[cur_link]  <= 1'b1;
              cnt                   <= '0;
              state                 <= S_RESET;
            end else begin
              link_failed[cur_link] <= 1'b1;
              delay_mode[cur_link]  <= 1'b0;
              visited[cur_link]     <= 1'b1;
              attempt               <= '0;
              state                 <= cur_last ? S_FINISH : S_SCAN;
            end
          end

          S_FINISH: begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= S_IDLE;
          end

          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_link_align_sequencer.sv
// tb_link_align_sequencer
// Randomized and directed bench. A behavioural per-link PHY model answers the
// sequencer's controls; a run-level reference model predicts lock/fail flags,
// delay modes and per-link pulse counts from the bring-up rules.

`timescale 1ns/1ps

module tb_link_align_sequencer;

  localparam int N      = 12;
  localparam int CW     = 32;
  localparam int RST    = 4;
  localparam int SETTLE = 64;
  localparam int DWELL  = 100;
  localparam int MAXR   = 3;
  localparam int THR    = 0;
  localparam int MINEYE = 16;
  localparam int LW     = $clog2(N);

  logic            clk160 = 1'b0;
  logic            rstb   = 1'b0;
  logic            start  = 1'b0;
  logic            abort  = 1'b0;
  logic [N-1:0]    link_enable   = '0;
  logic [N-1:0]    delay_ready   = '0;
  logic [N-1:0]    waiting_trans = '1;
  logic [N*CW-1:0] error_counter = '0;
  logic [N*9-1:0]  eye_width     = '0;
  logic [N-1:0]    link_resetn, counter_reset, latch_counters, delay_mode;
  logic            busy, done;
  logic [LW-1:0]   cur_link;
  logic [N-1:0]    link_locked, link_failed;

  link_align_sequencer #(
    .NLINKS(N), .COUNTER_WIDTH(CW), .RST_CYCLES(RST), .SETTLE_CYCLES(SETTLE),
    .DWELL_CYCLES(DWELL), .MAX_RETRIES(MAXR), .ERR_THRESHOLD(THR), .MIN_EYE(MINEYE)
  ) dut (
    .clk160(clk160), .rstb(rstb), .start(start), .abort(abort),
    .link_enable(link_enable), .delay_ready(delay_ready), .waiting_trans(waiting_trans),
    .error_counter(error_counter), .eye_width(eye_width),
    .link_resetn(link_resetn), .counter_reset(counter_reset), .latch_counters(latch_counters),
    .delay_mode(delay_mode), .busy(busy), .done(done), .cur_link(cur_link),
    .link_locked(link_locked), .link_failed(link_failed)
  );

  always #5 clk160 = ~clk160;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Per-link PHY behaviour plan
  int          ready_lat [N];        // cycles after reset release until ready, -1 = never
  int          wt_extra  [N];        // extra cycles waiting for transitions after ready
  int          eye_v     [N];
  logic [CW-1:0] err_plan [N][MAXR]; // latched error count per attempt
  bit          drop_plan [N][MAXR];  // ready drops mid-dwell on this attempt

  // PHY model state and monitor
  int          att      [N];
  int          since    [N];
  logic [CW-1:0] err_lat [N];
  logic [N-1:0] prev_rn = '1;
  int          rst_cnt  [N];
  int          clr_cnt  [N];
  int          lat_cnt  [N];
  int          low_len  [N];
  int          rel_cyc  [N];
  int          gap_min, gap_max;
  int          viol      = 0;
  int          done_cnt  = 0;
  int          busy_cnt  = 0;
  int          cyc       = 0;

  // Reference-model expectations
  logic [N-1:0] exp_locked, exp_failed;
  logic [N-1:0] dm_exp = '0;
  int           exp_rst [N];
  int           exp_clr [N];
  int           exp_lat [N];
  int           exp_cur;

  initial begin
    for (int i = 0; i < N; i++) begin
      since[i] = -1; err_lat[i] = '0; att[i] = -1; low_len[i] = 0; rel_cyc[i] = -1;
      rst_cnt[i] = 0; clr_cnt[i] = 0; lat_cnt[i] = 0;
    end
  end

  // Monitor outputs and drive the PHY responses, away from the rising edge.
  always @(negedge clk160) begin
    int active;
    int a;
    int settle_pt;
    logic rdy;
    cyc++;
    active = 0;
    if (done) done_cnt++;
    if (busy) busy_cnt++;
    for (int i = 0; i < N; i++) begin
      if (!link_resetn[i]) begin
        if (prev_rn[i]) begin
          rst_cnt[i]++;
          att[i]++;
          if (rel_cyc[i] >= 0) begin
            if (cyc - rel_cyc[i] < gap_min) gap_min = cyc - rel_cyc[i];
            if (cyc - rel_cyc[i] > gap_max) gap_max = cyc - rel_cyc[i];
          end
          low_len[i] = 0;
          err_lat[i] = '1;
        end
        low_len[i]++;
        since[i] = 0;
      end else begin
        if (!prev_rn[i]) begin
          if (low_len[i] != RST) viol++;
          rel_cyc[i] = cyc;
        end
        if (since[i] >= 0) since[i]++;
      end
      a = (att[i] < 0) ? 0 : ((att[i] >= MAXR) ? MAXR - 1 : att[i]);
      if (counter_reset[i]) clr_cnt[i]++;
      if (latch_counters[i]) begin
        lat_cnt[i]++;
        err_lat[i] = err_plan[i][a];
      end
      if (!link_resetn[i] || counter_reset[i] || latch_counters[i]) begin
        active++;
        if (i != int'(cur_link)) viol++;
      end
      if (link_locked[i] && link_failed[i]) viol++;
      prev_rn[i] = link_resetn[i];
      settle_pt = ready_lat[i] + wt_extra[i];
      rdy = (ready_lat[i] >= 0) && (since[i] >= ready_lat[i]);
      if (drop_plan[i][a] && since[i] >= settle_pt + 30 && since[i] <= settle_pt + 31) rdy = 1'b0;
      delay_ready[i]   = rdy;
      waiting_trans[i] = !(rdy && since[i] >= settle_pt);
      error_counter[i*CW +: CW] = err_lat[i];
      eye_width[i*9 +: 9]       = 9'(eye_v[i]);
    end
    if (active > 1) viol++;
    if (link_resetn != '1 && !busy) viol++;
  end

  task automatic tick();
    @(negedge clk160);
    #1;
  endtask

  task automatic plan_clear();
    for (int i = 0; i < N; i++) begin
      ready_lat[i] = 10; wt_extra[i] = 0; eye_v[i] = 40;
      for (int a = 0; a < MAXR; a++) begin
        err_plan[i][a] = '0; drop_plan[i][a] = 1'b0;
      end
    end
  endtask

  task automatic plan_random();
    logic [CW-1:0] errs [6];
    int            eyes [6];
    errs = '{32'd0, 32'd0, 32'd0, 32'd1, 32'd5, 32'hFFFF_FFFF};
    eyes = '{10, 15, 16, 17, 40, 511};
    for (int i = 0; i < N; i++) begin
      ready_lat[i] = ($urandom_range(0, 7) == 0) ? -1 : int'($urandom_range(1, 25));
      wt_extra[i]  = int'($urandom_range(0, 15));
      eye_v[i]     = ($urandom_range(0, 3) == 0) ? eyes[$urandom_range(0, 5)] : 40;
      for (int a = 0; a < MAXR; a++) begin
        err_plan[i][a]  = errs[$urandom_range(0, 5)];
        drop_plan[i][a] = ($urandom_range(0, 7) == 0);
      end
    end
  endtask

  // Run-level prediction straight from the bring-up rules.
  task automatic predict(input logic [N-1:0] en, input int abort_link);
    bit passed;
    exp_locked = '0; exp_failed = '0; exp_cur = 0;
    for (int i = 0; i < N; i++) begin
      exp_rst[i] = 0; exp_clr[i] = 0; exp_lat[i] = 0;
    end
    for (int i = 0; i < N; i++) begin
      if (en[i] && !(abort_link >= 0 && i > abort_link)) begin
        exp_cur = i;
        if (i == abort_link) begin
          exp_rst[i] = 1; exp_clr[i] = 1; dm_exp[i] = 1'b0;
        end else begin
          passed = 1'b0;
          for (int a = 0; a < MAXR && !passed; a++) begin
            exp_rst[i]++;
            if (ready_lat[i] >= 0) begin
              exp_clr[i]++;
              if (!drop_plan[i][a]) begin
                exp_lat[i]++;
                if (err_plan[i][a] <= CW'(THR) && eye_v[i] >= MINEYE) passed = 1'b1;
              end
            end
          end
          exp_locked[i] = passed;
          exp_failed[i] = !passed;
          dm_exp[i]     = passed;
        end
      end
    end
  endtask

  task automatic monitor_clear();
    for (int i = 0; i < N; i++) begin
      rst_cnt[i] = 0; clr_cnt[i] = 0; lat_cnt[i] = 0; att[i] = -1; rel_cyc[i] = -1;
    end
    gap_min = 1 << 30; gap_max = 0; viol = 0; done_cnt = 0; busy_cnt = 0;
  endtask

  task automatic run(input string tag, input logic [N-1:0] en, input int abort_link, input bit poke_start);
    int t;
    int after_clr;
    int t_ab;
    monitor_clear();
    predict(en, abort_link);
    tick();
    link_enable = en;
    start = 1'b1;
    tick();
    start = 1'b0;
    link_enable = N'($urandom);
    t = 1; after_clr = 0; t_ab = -1;
    while (done_cnt == 0 && t < 20000) begin
      tick();
      t++;
      if (poke_start && t == 40) start = 1'b1;
      if (poke_start && t == 41) start = 1'b0;
      if (abort_link >= 0 && t_ab < 0 && clr_cnt[abort_link] > 0) begin
        after_clr++;
        if (after_clr == 10) begin
          abort = 1'b1;
          tick();
          t++;
          abort = 1'b0;
          t_ab = t;
          check({tag, "_abort_rstn"}, link_resetn, {N{1'b1}});
          check({tag, "_abort_pulses"}, {counter_reset, latch_counters}, '0);
          check({tag, "_abort_dm"}, delay_mode[abort_link], 1'b0);
          check({tag, "_abort_done_early"}, done, 1'b0);
        end
      end
    end
    if (done_cnt == 0) begin
      check({tag, "_done_timeout"}, 0, 1);
      return;
    end
    if (abort_link >= 0) check({tag, "_abort_done_lat"}, t - t_ab, 1);
    check({tag, "_busy_end"}, busy, 1'b0);
    check({tag, "_rstn_end"}, link_resetn, {N{1'b1}});
    check({tag, "_locked"}, link_locked, exp_locked);
    check({tag, "_failed"}, link_failed, exp_failed);
    check({tag, "_delay_mode"}, delay_mode, dm_exp);
    check({tag, "_cur_link"}, cur_link, exp_cur);
    check({tag, "_busy_seen"}, busy_cnt > 0, en != '0);
    for (int i = 0; i < N; i++) begin
      check($sformatf("%s_rst_cnt%0d", tag, i), rst_cnt[i], exp_rst[i]);
      check($sformatf("%s_clr_cnt%0d", tag, i), clr_cnt[i], exp_clr[i]);
      check($sformatf("%s_lat_cnt%0d", tag, i), lat_cnt[i], exp_lat[i]);
    end
    tick();
    check({tag, "_done_width"}, done, 1'b0);
    check({tag, "_protocol"}, viol, 0);
  endtask

  initial begin
    plan_clear();
    // Reset values
    tick();
    tick();
    check("rst_rstn", link_resetn, {N{1'b1}});
    check("rst_ctrl", {counter_reset, latch_counters, delay_mode}, '0);
    check("rst_flags", {link_locked, link_failed}, '0);
    check("rst_status", {busy, done, cur_link}, '0);
    rstb = 1'b1;
    tick();

    // Two good links
    plan_clear();
    run("t2", 12'h005, -1, 1'b0);

    // Empty enable: done three cycles after start, busy never set
    monitor_clear();
    link_enable = '0;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("t1_done_c1", done, 1'b0);
    tick();
    check("t1_done_c2", done, 1'b0);
    tick();
    check("t1_done_c3", done, 1'b1);
    check("t1_flags", {link_locked, link_failed}, '0);
    check("t1_cur_link", cur_link, 0);
    tick();
    check("t1_done_c4", done, 1'b0);
    check("t1_busy_never", busy_cnt, 0);

    // Link never ready: three timed-out attempts
    plan_clear();
    ready_lat[1] = -1;
    run("t3", 12'h002, -1, 1'b0);
    check("t3_timeout_len", (gap_min >= SETTLE) && (gap_max <= SETTLE + 2), 1'b1);
    check("t3_dm1", delay_mode[1], 1'b0);

    // Errors on first attempt, clean on retry
    plan_clear();
    err_plan[0][0] = 32'd5;
    run("t4", 12'h001, -1, 1'b0);

    // Thresholds, drops, slow transitions, last-index failure; start poked while busy
    plan_clear();
    eye_v[3] = 16;
    eye_v[4] = 15;
    err_plan[5] = '{32'd1, 32'd1, 32'd1};
    err_plan[6] = '{32'd1, 32'd1, 32'd0};
    drop_plan[7][0] = 1'b1;
    wt_extra[8] = 20;
    ready_lat[11] = -1;
    run("bnd", 12'hFF8, -1, 1'b1);

    // Pass at the last index
    plan_clear();
    run("last", 12'h800, -1, 1'b0);

    // Abort during link 2 dwell
    plan_clear();
    run("t5", 12'h00F, 2, 1'b0);

    // start together with abort in IDLE is ignored
    monitor_clear();
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    for (int k = 0; k < 5; k++) tick();
    check("idle_abort_done", done_cnt, 0);
    check("idle_abort_busy", busy_cnt, 0);

    // Randomized runs
    for (int r = 0; r < 6; r++) begin
      plan_random();
      run($sformatf("rnd%0d", r), N'($urandom), -1, r[0]);
    end

    // Asynchronous reset mid-dwell
    plan_clear();
    monitor_clear();
    tick();
    link_enable = 12'h001;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 2000 && clr_cnt[0] == 0; k++) tick();
    for (int k = 0; k < 10; k++) tick();
    check("t6_in_dwell", {delay_mode[0], busy}, 2'b11);
    done_cnt = 0;
    #2 rstb = 1'b0;
    #1;
    check("t6_rstn", link_resetn, {N{1'b1}});
    check("t6_ctrl", {counter_reset, latch_counters, delay_mode}, '0);
    check("t6_flags", {link_locked, link_failed}, '0);
    check("t6_status", {busy, done, cur_link}, '0);
    for (int k = 0; k < 4; k++) tick();
    check("t6_no_done", done_cnt, 0);
    rstb = 1'b1;
    tick();
    tick();
    check("t6_after", {busy, done}, 2'b00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
